ps2_keyboard_receiver: RTL and testbench

Receive-only PS/2 keyboard interface between the board's PS2KeyboardClk/PS2KeyboardData pins and the HC800 I/O space. Synchronises and glitch-filters the PS/2 lines, deframes 11-bit device-to-host frames, checks start/parity/stop, and queues good scancode bytes in a small FIFO popped by the CPU. Host-to-device transmission is out of scope; the top level leaves both pins released (high-Z) and feeds them to this block as inputs.

---
 rtl/ps2_pkg.sv | 20 ++
 rtl/ps2_line_filter.sv | 38 +++
 rtl/ps2_keyboard_receiver.sv | 138 +++++++++++++
 tb/tb_ps2_keyboard_receiver.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants and helpers for the PS/2 keyboard receiver.
package ps2_pkg;

  typedef logic [1:0] ps2_state_t;

  localparam ps2_state_t ST_IDLE   = 2'd0;
  localparam ps2_state_t ST_DATA   = 2'd1;
  localparam ps2_state_t ST_PARITY = 2'd2;
  localparam ps2_state_t ST_STOP   = 2'd3;

  localparam int FRAME_BITS             = 8;
  localparam int DEFAULT_FILTER_LEN     = 8;
  localparam int DEFAULT_TIMEOUT_CYCLES = 50000;

  // PS/2 uses odd parity across the data byte plus the parity bit.
  function automatic logic parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a run-length glitch filter for one PS/2 line.
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = DEFAULT_FILTER_LEN
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filt
);

  logic       sync1;
  logic       sync2;
  logic [7:0] cnt;

  // The line flips only on the FILTER_LEN-th consecutive differing sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      cnt   <= 8'd0;
      filt  <= 1'b1;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == filt) begin
        cnt <= 8'd0;
      end else if (cnt == 8'(FILTER_LEN - 1)) begin
        filt <= sync2;
        cnt  <= 8'd0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/ps2_keyboard_receiver.sv
// Receive-only PS/2 keyboard port: filters the pins, deframes 11-bit frames,
// and queues good scancodes in a small FIFO popped by the CPU.
module ps2_keyboard_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN      = DEFAULT_FILTER_LEN,
  parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic                     bus_clk,
  input  logic                     bus_reset,
  input  logic                     ps2_clk_in,
  input  logic                     ps2_data_in,
  output logic [7:0]               kbd_data,
  output logic                     kbd_valid,
  output logic [FIFO_DEPTH_LOG2:0] kbd_count,
  input  logic                     kbd_read,
  output logic                     kbd_overflow,
  output logic                     kbd_frame_err,
  input  logic                     kbd_clear_err
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FIFO_DEPTH_LOG2:0] CNT_FULL = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};

  logic clk_f, data_f, clk_prev, fall;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk(bus_clk), .reset(bus_reset), .raw(ps2_clk_in), .filt(clk_f)
  );
  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk(bus_clk), .reset(bus_reset), .raw(ps2_data_in), .filt(data_f)
  );

  always_ff @(posedge bus_clk) begin
    if (bus_reset) clk_prev <= 1'b1;
    else           clk_prev <= clk_f;
  end

  assign fall = clk_prev & ~clk_f;

  ps2_state_t        state;
  logic [2:0]        bit_idx;
  logic [7:0]        shreg;
  logic              par_bit;
  logic [TW-1:0]     to_cnt;
  logic              timeout, frame_ok, push_req, frame_bad;

  assign timeout   = (state != ST_IDLE) && !fall && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign frame_ok  = data_f && parity_ok(shreg, par_bit);
  assign push_req  = fall && (state == ST_STOP) && frame_ok;
  assign frame_bad = fall && (((state == ST_IDLE) && data_f) ||
                              ((state == ST_STOP) && !frame_ok));

  always_ff @(posedge bus_clk) begin
    if (bus_reset) begin
      state   <= ST_IDLE;
      bit_idx <= 3'd0;
      shreg   <= 8'd0;
      par_bit <= 1'b0;
      to_cnt  <= '0;
    end else begin
      if ((state == ST_IDLE) || fall) to_cnt <= '0;
      else                            to_cnt <= to_cnt + 1'b1;

      if (timeout) begin
        state <= ST_IDLE;
      end else if (fall) begin
        case (state)
          ST_IDLE: if (!data_f) begin
            state   <= ST_DATA;
            bit_idx <= 3'd0;
          end
          ST_DATA: begin
            // LSB arrives first, so shift toward bit 0.
            shreg   <= {data_f, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'(FRAME_BITS - 1)) state <= ST_PARITY;
          end
          ST_PARITY: begin
            par_bit <= data_f;
            state   <= ST_STOP;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  logic [7:0]                 mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wptr, rptr;
  logic [FIFO_DEPTH_LOG2:0]   count;
  logic                       full, do_push, do_pop;

  assign full    = (count == CNT_FULL);
  assign do_pop  = kbd_read && (count != '0);
  // A full FIFO still accepts a byte when a pop frees the slot in the same cycle.
  assign do_push = push_req && (!full || do_pop);

  always_ff @(posedge bus_clk) begin
    if (do_push) mem[wptr] <= shreg;
  end

  always_ff @(posedge bus_clk) begin
    if (bus_reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign kbd_valid = (count != '0);
  assign kbd_count = count;
  assign kbd_data  = kbd_valid ? mem[rptr] : 8'h00;

  always_ff @(posedge bus_clk) begin
    if (bus_reset) begin
      kbd_overflow  <= 1'b0;
      kbd_frame_err <= 1'b0;
    end else begin
      if (push_req && full && !do_pop) kbd_overflow <= 1'b1;
      else if (kbd_clear_err)          kbd_overflow <= 1'b0;

      if (frame_bad || timeout) kbd_frame_err <= 1'b1;
      else if (kbd_clear_err)   kbd_frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
// Scoreboard bench: stimulus queues expected bytes, a monitor checks every pop.
module tb_ps2_keyboard_receiver;

  localparam int F    = 4;
  localparam int TO   = 400;
  localparam int DL2  = 3;
  localparam int HALF = 20;

  logic         bus_clk = 1'b0;
  logic         bus_reset = 1'b1;
  logic         ps2_clk_in = 1'b1;
  logic         ps2_data_in = 1'b1;
  logic         kbd_read = 1'b0;
  logic         kbd_clear_err = 1'b0;
  logic [7:0]   kbd_data;
  logic         kbd_valid;
  logic [DL2:0] kbd_count;
  logic         kbd_overflow;
  logic         kbd_frame_err;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q [$];

  logic [7:0] tbl_a [9] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
  logic [7:0] tbl_b [8] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E};

  always #5 bus_clk = ~bus_clk;

  ps2_keyboard_receiver #(.FILTER_LEN(F), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH_LOG2(DL2)) dut (
    .bus_clk(bus_clk), .bus_reset(bus_reset), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .kbd_data(kbd_data), .kbd_valid(kbd_valid), .kbd_count(kbd_count), .kbd_read(kbd_read),
    .kbd_overflow(kbd_overflow), .kbd_frame_err(kbd_frame_err), .kbd_clear_err(kbd_clear_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge bus_clk) begin : monitor
    logic [7:0] e;
    if (!bus_reset && kbd_read && kbd_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_unexpected: got %0h want none", kbd_data);
      end else begin
        e = exp_q.pop_front();
        check("pop_data", {24'h0, kbd_data}, {24'h0, e});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge bus_clk);
    #1;
  endtask

  // frame bit 0 is the start bit; parity bit makes data+parity odd
  function automatic logic [10:0] mk(input logic [7:0] d, input logic par_flip);
    return {1'b1, (~^d) ^ par_flip, d, 1'b0};
  endfunction

  // mode 0: plain; 1: check kbd_valid edge around the stop fall; 2: pop on the stop fall
  task automatic send_bits(input logic [10:0] fr, input int nbits, input int mode);
    for (int i = 0; i < nbits; i++) begin
      ps2_data_in = fr[i];
      cyc(HALF);
      ps2_clk_in = 1'b0;
      if (i == 10 && mode == 1) begin
        repeat (F + 2) @(posedge bus_clk);
        @(negedge bus_clk);
        check("valid_before_push", {31'h0, kbd_valid}, 32'h0);
        @(posedge bus_clk);
        @(negedge bus_clk);
        check("valid_after_push", {31'h0, kbd_valid}, 32'h1);
        cyc(HALF - F - 3);
      end else if (i == 10 && mode == 2) begin
        repeat (F + 2) @(posedge bus_clk);
        #1 kbd_read = 1'b1;
        @(posedge bus_clk);
        #1 kbd_read = 1'b0;
        cyc(HALF - F - 3);
      end else begin
        cyc(HALF);
      end
      ps2_clk_in = 1'b1;
    end
    ps2_data_in = 1'b1;
    cyc(HALF);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic expect_push, input int mode);
    if (expect_push) exp_q.push_back(d);
    send_bits(mk(d, 1'b0), 11, mode);
    cyc(10);
  endtask

  task automatic pop();
    kbd_read = 1'b1;
    cyc(1);
    kbd_read = 1'b0;
    cyc(1);
  endtask

  task automatic clear_err();
    kbd_clear_err = 1'b1;
    cyc(1);
    kbd_clear_err = 1'b0;
  endtask

  initial begin
    cyc(3);
    bus_reset = 1'b0;
    cyc(2);
    check("rst_valid", {31'h0, kbd_valid}, 32'h0);
    check("rst_count", {28'h0, kbd_count}, 32'h0);
    check("rst_data", {24'h0, kbd_data}, 32'h0);
    check("rst_ovf", {31'h0, kbd_overflow}, 32'h0);
    check("rst_err", {31'h0, kbd_frame_err}, 32'h0);

    send_byte(8'h1C, 1'b1, 1);
    check("b1c_count", {28'h0, kbd_count}, 32'h1);
    check("b1c_data", {24'h0, kbd_data}, 32'h1C);
    check("b1c_err", {31'h0, kbd_frame_err}, 32'h0);
    check("b1c_ovf", {31'h0, kbd_overflow}, 32'h0);
    pop();
    check("b1c_popped_count", {28'h0, kbd_count}, 32'h0);
    check("b1c_popped_valid", {31'h0, kbd_valid}, 32'h0);

    send_bits(mk(8'hF0, 1'b1), 11, 0);
    cyc(10);
    check("badpar_count", {28'h0, kbd_count}, 32'h0);
    check("badpar_err", {31'h0, kbd_frame_err}, 32'h1);
    clear_err();
    check("badpar_cleared", {31'h0, kbd_frame_err}, 32'h0);

    for (int i = 0; i < 9; i++) send_byte(tbl_a[i], i < 8, 0);
    check("ovf_count", {28'h0, kbd_count}, 32'h8);
    check("ovf_flag", {31'h0, kbd_overflow}, 32'h1);
    check("ovf_err", {31'h0, kbd_frame_err}, 32'h0);
    for (int i = 0; i < 8; i++) pop();
    check("ovf_drained", {28'h0, kbd_count}, 32'h0);
    check("ovf_q_empty", exp_q.size(), 32'h0);
    clear_err();
    check("ovf_cleared", {31'h0, kbd_overflow}, 32'h0);

    for (int i = 0; i < 8; i++) send_byte(tbl_b[i], 1'b1, 0);
    send_byte(8'h66, 1'b1, 2);
    check("pushpop_count", {28'h0, kbd_count}, 32'h8);
    check("pushpop_ovf", {31'h0, kbd_overflow}, 32'h0);
    for (int i = 0; i < 8; i++) pop();
    check("pushpop_drained", {28'h0, kbd_count}, 32'h0);
    check("pushpop_q_empty", exp_q.size(), 32'h0);

    send_bits(mk(8'h3B, 1'b0), 5, 0);
    check("to_pending_err", {31'h0, kbd_frame_err}, 32'h0);
    cyc(TO + 20);
    check("to_err", {31'h0, kbd_frame_err}, 32'h1);
    check("to_count", {28'h0, kbd_count}, 32'h0);
    clear_err();
    send_byte(8'h5A, 1'b1, 0);
    check("to_next_count", {28'h0, kbd_count}, 32'h1);
    check("to_next_err", {31'h0, kbd_frame_err}, 32'h0);
    pop();

    for (int i = 0; i < 5; i++) begin
      ps2_clk_in = 1'b0;
      cyc(F - 1);
      ps2_clk_in = 1'b1;
      cyc(10);
    end
    check("glitch_err", {31'h0, kbd_frame_err}, 32'h0);
    check("glitch_count", {28'h0, kbd_count}, 32'h0);

    send_byte(8'h29, 1'b0, 0);
    send_bits(11'h7FF, 1, 0);
    cyc(10);
    check("pre_rst_err", {31'h0, kbd_frame_err}, 32'h1);
    check("pre_rst_count", {28'h0, kbd_count}, 32'h1);
    send_bits(mk(8'h3C, 1'b0), 4, 0);
    bus_reset = 1'b1;
    cyc(2);
    bus_reset = 1'b0;
    cyc(1);
    check("mid_rst_valid", {31'h0, kbd_valid}, 32'h0);
    check("mid_rst_count", {28'h0, kbd_count}, 32'h0);
    check("mid_rst_data", {24'h0, kbd_data}, 32'h0);
    check("mid_rst_err", {31'h0, kbd_frame_err}, 32'h0);
    check("mid_rst_ovf", {31'h0, kbd_overflow}, 32'h0);
    send_byte(8'h76, 1'b1, 0);
    check("post_rst_count", {28'h0, kbd_count}, 32'h1);
    check("post_rst_data", {24'h0, kbd_data}, 32'h76);
    pop();
    check("final_q_empty", exp_q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "bench stalled");
  end

endmodule
